pg_rca_share_ctrl: RTL and testbench

PG_RCA_SHARE_CTRL -- requirements
Module: pg_rca_share_ctrl

---
 rtl/pg_rca_share_pkg.sv | 16 +
 rtl/s_pg_rca12.sv | 31 +++
 rtl/pg_rca_share_ctrl.sv | 118 +++++++++++
 tb/tb_pg_rca_share_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pg_rca_share_pkg.sv
// pg_rca_share_pkg
//   Shared constants and helpers for the shared ripple-carry adder block.
//   OPND_W : width of each signed operand
//   SUM_W  : width of the exact signed sum
//   rr_inc : round-robin pointer increment with wrap to 0 at nreq
package pg_rca_share_pkg;

  localparam int OPND_W = 12;
  localparam int SUM_W  = 13;

  // Next round-robin start position after index ptr was served.
  function automatic int unsigned rr_inc(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/s_pg_rca12.sv
// s_pg_rca12
//   Signed 12-bit propagate/generate ripple-carry adder, purely combinational.
//   a_i   [11:0] : signed operand A
//   b_i   [11:0] : signed operand B
//   sum_o [12:0] : exact signed sum A+B
module s_pg_rca12
  import pg_rca_share_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  output logic [SUM_W-1:0]  sum_o
);

  logic [OPND_W-1:0] p;
  logic [OPND_W-1:0] g;
  logic [OPND_W:0]   c;

  assign p    = a_i ^ b_i;
  assign g    = a_i & b_i;
  assign c[0] = 1'b0;

  for (genvar gi = 0; gi < OPND_W; gi++) begin : g_bit
    assign c[gi+1]   = g[gi] | (p[gi] & c[gi]);
    assign sum_o[gi] = p[gi] ^ c[gi];
  end

  // Sign bit of the sign-extended sum: extension bits are a[11] and b[11],
  // so the extra bit is their XOR combined with the carry out of bit 11.
  assign sum_o[SUM_W-1] = p[OPND_W-1] ^ c[OPND_W];

endmodule

// File: rtl/pg_rca_share_ctrl.sv
// pg_rca_share_ctrl
//   Shares one signed 12-bit adder among NREQ requesters using a round-robin
//   arbiter, an NREQ:1 operand mux and a single-entry result register.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_a/b    : packed signed operands, requester i in bits [12i+11:12i]
//   out_valid  : result register holds an unconsumed result
//   out_ready  : consumer accepts the result
//   out_sum    : exact 13-bit signed sum
//   out_id     : requester that owns out_sum
module pg_rca_share_ctrl
  import pg_rca_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OPND_W-1:0] req_a,
  input  logic [NREQ*OPND_W-1:0] req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       out_sum,
  output logic [IDW-1:0]         out_id
);

  logic [OPND_W-1:0] a_arr [NREQ];
  logic [OPND_W-1:0] b_arr [NREQ];
  logic [OPND_W-1:0] a_sel;
  logic [OPND_W-1:0] b_sel;
  logic [SUM_W-1:0]  sum_w;

  logic [IDW-1:0]    rr_ptr_q,    rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_sum_q,   out_sum_d;
  logic [IDW-1:0]    out_id_q,    out_id_d;

  logic [NREQ-1:0]   grant_oh;
  logic [IDW-1:0]    grant_idx;
  logic              found;
  logic              can_accept;
  logic              xfer;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*OPND_W +: OPND_W];
    assign b_arr[gi] = req_b[gi*OPND_W +: OPND_W];
  end

  // Round-robin search: first valid index at or after rr_ptr, modulo NREQ.
  // Grants are also masked by rst_n so req_ready stays low during reset.
  always_comb begin
    grant_oh   = '0;
    grant_idx  = '0;
    found      = 1'b0;
    can_accept = !out_valid_q || out_ready;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found     = 1'b1;
        grant_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    if (found && can_accept && rst_n) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign xfer      = |grant_oh;
  assign req_ready = grant_oh;

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];

  s_pg_rca12 u_add (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .sum_o (sum_w)
  );

  // A new transfer overwrites the result even when the old one is being
  // consumed in the same cycle, so back-to-back results have no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_w;
      out_id_d    = grant_idx;
      rr_ptr_d    = IDW'(rr_inc(int'(grant_idx), NREQ));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_pg_rca_share_ctrl.sv
// tb_pg_rca_share_ctrl
//   Directed and random traffic for pg_rca_share_ctrl (NREQ=4). Expected
//   results are queued when an accept is expected and checked by a monitor
//   whenever out_valid is presented.
module tb_pg_rca_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [47:0] req_a = '0;
  logic [47:0] req_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_sum;
  logic [1:0]  out_id;

  typedef struct {
    logic [1:0]  id;
    logic [12:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pg_rca_share_ctrl #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic set_ops(input logic [11:0] a0, input logic [11:0] b0,
                         input logic [11:0] a1, input logic [11:0] b1,
                         input logic [11:0] a2, input logic [11:0] b2,
                         input logic [11:0] a3, input logic [11:0] b3);
    req_a = {a3, a2, a1, a0};
    req_b = {b3, b2, b1, b0};
  endtask

  // One cycle of directed stimulus: expected one-hot accept and, if any,
  // the hand-computed sum the granted requester should produce.
  task automatic step(input string nm, input logic [3:0] v, input logic ordy,
                      input logic [3:0] exp_rdy, input logic [12:0] exp_sum);
    @(posedge clk);
    #1;
    req_valid = v;
    out_ready = ordy;
    @(negedge clk);
    #1;
    chk({nm, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) sb.push_back('{id: oh2id(exp_rdy), sum: exp_sum});
    $display("%s: valid=%b out_ready=%b req_ready=%b", nm, v, ordy, req_ready);
  endtask

  // Monitor: every presented result must match the oldest expectation; it
  // is only retired when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got id=%0d sum=%0h expected no result", out_id, out_sum);
      end else begin
        chk("out_id", 32'(out_id), 32'(sb[0].id));
        chk("out_sum", 32'(out_sum), 32'(sb[0].sum));
        $display("result id=%0d sum=%0h out_ready=%b", out_id, out_sum, out_ready);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  logic [11:0]        pa[4];
  logic [11:0]        pb[4];
  logic [3:0]         pv;
  logic signed [12:0] ea, eb;
  logic [1:0]         g;

  initial begin
    // Reset state with every requester asserting.
    set_ops(12'h001, 12'h002, 12'h064, 12'hFFF, 12'hED4, 12'h032, 12'h3E8, 12'h3E8);
    req_valid = 4'b1111;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_id",    32'(out_id),    32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    // All requesters continuously valid: grants 0,1,2,3,0,1.
    step("rr0", 4'b1111, 1'b1, 4'b0001, 13'h0003);
    step("rr1", 4'b1111, 1'b1, 4'b0010, 13'h0063);
    step("rr2", 4'b1111, 1'b1, 4'b0100, 13'h1F06);
    step("rr3", 4'b1111, 1'b1, 4'b1000, 13'h07D0);
    step("rr4", 4'b1111, 1'b1, 4'b0001, 13'h0003);
    step("rr5", 4'b1111, 1'b1, 4'b0010, 13'h0063);
    step("idle1", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // rr_ptr is now 2: requester 3 wins before 1.
    set_ops(12'h000, 12'h000, 12'h064, 12'h017, 12'h000, 12'h000, 12'hFFB, 12'hFF9);
    step("wrap3", 4'b1010, 1'b1, 4'b1000, 13'h1FF4);
    step("wrap1", 4'b0010, 1'b1, 4'b0010, 13'h007B);
    step("idle2", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // Largest positive operands.
    set_ops(12'h7FF, 12'h7FF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    step("maxpos", 4'b0001, 1'b1, 4'b0001, 13'h0FFE);
    step("idle3", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // Most negative operands, then a cancelling pair.
    set_ops(12'h000, 12'h000, 12'hFFF, 12'h001, 12'h800, 12'h800, 12'h000, 12'h000);
    step("maxneg", 4'b0100, 1'b1, 4'b0100, 13'h1000);
    step("zero", 4'b0010, 1'b1, 4'b0010, 13'h0000);
    step("idle4", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // Backpressure for three cycles; monitor checks the held result.
    set_ops(12'h001, 12'h002, 12'h064, 12'hFFF, 12'hED4, 12'h032, 12'h3E8, 12'h3E8);
    step("bp_acc", 4'b1111, 1'b1, 4'b0100, 13'h1F06);
    step("bp_h0", 4'b1111, 1'b0, 4'b0000, 13'h0000);
    step("bp_h1", 4'b1111, 1'b0, 4'b0000, 13'h0000);
    step("bp_h2", 4'b1111, 1'b0, 4'b0000, 13'h0000);
    step("bp_rel", 4'b1111, 1'b1, 4'b1000, 13'h07D0);
    step("idle5", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // Reset while a result is stalled.
    step("r_acc", 4'b0001, 1'b0, 4'b0001, 13'h0003);
    step("r_hold", 4'b0000, 1'b0, 4'b0000, 13'h0000);
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum",   32'(out_sum),   32'd0);
    chk("mid_rst_id",    32'(out_id),    32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    step("post_rst1", 4'b0110, 1'b1, 4'b0010, 13'h0063);
    step("post_rst2", 4'b0100, 1'b1, 4'b0100, 13'h1F06);
    step("idle6", 4'b0000, 1'b1, 4'b0000, 13'h0000);

    // Random traffic: operands held until accepted, random backpressure.
    pv = '0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 12'($urandom);
      pb[i] = 12'($urandom);
    end
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[i] = 12'($urandom);
          pb[i] = 12'($urandom);
        end
      end
      @(posedge clk);
      #1;
      req_valid = pv;
      out_ready = ($urandom_range(0, 3) != 0);
      req_a = {pa[3], pa[2], pa[1], pa[0]};
      req_b = {pb[3], pb[2], pb[1], pb[0]};
      @(negedge clk);
      #1;
      chk("rnd_onehot", 32'($onehot0(req_ready)), 32'd1);
      chk("rnd_subset", 32'(req_ready & ~pv), 32'd0);
      if (req_ready != 4'b0) begin
        g  = oh2id(req_ready);
        ea = $signed(pa[g]);
        eb = $signed(pb[g]);
        sb.push_back('{id: g, sum: 13'(ea + eb)});
        $display("rnd accept id=%0d a=%0h b=%0h", g, pa[g], pb[g]);
        pv[g] = 1'b0;
      end
    end

    // Drain and confirm every accepted operation came out.
    step("drain0", 4'b0000, 1'b1, 4'b0000, 13'h0000);
    step("drain1", 4'b0000, 1'b1, 4'b0000, 13'h0000);
    step("drain2", 4'b0000, 1'b1, 4'b0000, 13'h0000);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
